// File: rtl/nm_bus_pkg.sv
// Shared types and constants for the neuron-network register bus master.
package nm_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWait,
        StHold
    } nm_state_e;

    localparam logic [3:0] NETWORK_STATUS = 4'hD;
    localparam logic [3:0] FORGET         = 4'hF;

    localparam int unsigned SETUP_CYC_DEF    = 1;
    localparam int unsigned STROBE_CYC_DEF   = 2;
    localparam int unsigned WAIT_IGN_CYC_DEF = 1;
    localparam int unsigned TIMEOUT_CYC_DEF  = 1023;

    localparam int unsigned PHASE_W   = 4;
    localparam int unsigned TIMEOUT_W = 10;

endpackage

// File: rtl/nm_bus_timer.sv
// Loadable down-counter that saturates at zero; o_expired is high while the count is zero.
module nm_bus_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/nm_bus_master.sv
// Host-command to neuron-network register bus master: SETUP/STROBE/WAIT/HOLD access sequencing
// with registered bus outputs, RDY wait with timeout, and a one-cycle response pulse.
module nm_bus_master
    import nm_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = SETUP_CYC_DEF,
    parameter int unsigned STROBE_CYC   = STROBE_CYC_DEF,
    parameter int unsigned WAIT_IGN_CYC = WAIT_IGN_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
    input  logic        G_CLK,
    input  logic        G_RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        CS_l,
    output logic        DS,
    output logic        RW_l,
    output logic [3:0]  REG,
    output logic [15:0] DATA_O,
    output logic        DATA_OE,
    input  logic [15:0] DATA_I,
    input  logic        RDY
);

    nm_state_e r_state;
    logic        r_write;
    logic        r_timeout;
    logic [15:0] r_rdata;
    logic        r_cs_l, r_ds, r_rw_l, r_data_oe, r_cmd_ready;
    logic        r_rsp_valid, r_rsp_timeout;
    logic [3:0]  r_reg;
    logic [15:0] r_data_o, r_rsp_rdata;

    logic               w_accept, w_rdy_ok;
    logic               w_ph_load, w_ph_expired;
    logic [PHASE_W-1:0] w_ph_val;
    logic               w_to_load, w_to_expired;

    // Phase timer is reloaded on every phase entry; in WAIT it counts the RDY-ignore window.
    always_comb begin
        w_accept  = (r_state == StIdle) && cmd_valid;
        w_rdy_ok  = (r_state == StWait) && w_ph_expired && RDY;
        w_ph_load = 1'b0;
        w_ph_val  = '0;
        w_to_load = 1'b0;
        if (w_accept) begin
            w_ph_load = 1'b1;
            w_ph_val  = PHASE_W'(SETUP_CYC - 1);
        end else if ((r_state == StSetup) && w_ph_expired) begin
            w_ph_load = 1'b1;
            w_ph_val  = PHASE_W'(STROBE_CYC - 1);
        end else if ((r_state == StStrobe) && w_ph_expired) begin
            w_ph_load = 1'b1;
            w_ph_val  = PHASE_W'(WAIT_IGN_CYC);
            w_to_load = 1'b1;
        end
    end

    nm_bus_timer #(.WIDTH(PHASE_W)) u_phase_timer (
        .i_clk      (G_CLK),
        .i_rst      (G_RESET),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .o_expired  (w_ph_expired)
    );

    nm_bus_timer #(.WIDTH(TIMEOUT_W)) u_timeout_timer (
        .i_clk      (G_CLK),
        .i_rst      (G_RESET),
        .i_load     (w_to_load),
        .i_load_val (TIMEOUT_W'(TIMEOUT_CYC - 1)),
        .o_expired  (w_to_expired)
    );

    always_ff @(posedge G_CLK) begin
        if (G_RESET) begin
            r_state       <= StIdle;
            r_write       <= 1'b0;
            r_timeout     <= 1'b0;
            r_rdata       <= '0;
            r_cs_l        <= 1'b1;
            r_ds          <= 1'b0;
            r_rw_l        <= 1'b1;
            r_reg         <= '0;
            r_data_o      <= '0;
            r_data_oe     <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state     <= StSetup;
                        r_write     <= cmd_write;
                        r_cmd_ready <= 1'b0;
                        r_cs_l      <= 1'b0;
                        r_reg       <= cmd_reg;
                        r_rw_l      <= ~cmd_write;
                        r_data_o    <= cmd_wdata;
                        r_data_oe   <= cmd_write;
                    end
                end
                StSetup: begin
                    if (w_ph_expired) begin
                        r_state <= StStrobe;
                        r_ds    <= 1'b1;
                    end
                end
                StStrobe: begin
                    if (w_ph_expired) begin
                        r_state <= StWait;
                        r_ds    <= 1'b0;
                    end
                end
                StWait: begin
                    // A qualified RDY wins over a timeout expiring in the same cycle.
                    if (w_rdy_ok) begin
                        r_state   <= StHold;
                        r_rdata   <= r_write ? '0 : DATA_I;
                        r_timeout <= 1'b0;
                    end else if (w_to_expired) begin
                        r_state   <= StHold;
                        r_rdata   <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                StHold: begin
                    r_state       <= StIdle;
                    r_cs_l        <= 1'b1;
                    r_rw_l        <= 1'b1;
                    r_reg         <= '0;
                    r_data_o      <= '0;
                    r_data_oe     <= 1'b0;
                    r_cmd_ready   <= 1'b1;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_rdata   <= r_rdata;
                    r_rsp_timeout <= r_timeout;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;
    assign CS_l        = r_cs_l;
    assign DS          = r_ds;
    assign RW_l        = r_rw_l;
    assign REG         = r_reg;
    assign DATA_O      = r_data_o;
    assign DATA_OE     = r_data_oe;

endmodule

// File: tb/tb_nm_bus_master.sv
// Directed self-checking bench for nm_bus_master: timing of write/read/timeout/back-to-back,
// reset mid-access, and a single-cycle strobe variant.
module tb_nm_bus_master;
    import nm_bus_pkg::*;

    logic        G_CLK = 1'b0;
    logic        G_RESET;
    logic        cmd_valid, cmd_valid2, cmd_write;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_wdata, DATA_I;
    logic        RDY;

    logic        cmd_ready, rsp_valid, rsp_timeout, CS_l, DS, RW_l, DATA_OE;
    logic [15:0] rsp_rdata, DATA_O;
    logic [3:0]  REG;

    logic        cmd_ready_2, rsp_valid_2, rsp_timeout_2, CS_l_2, DS_2, RW_l_2, DATA_OE_2;
    logic [15:0] rsp_rdata_2, DATA_O_2;
    logic [3:0]  REG_2;

    int n_vec = 0;
    int n_err = 0;

    always #5 G_CLK = ~G_CLK;

    nm_bus_master #(.SETUP_CYC(1), .STROBE_CYC(2), .WAIT_IGN_CYC(1), .TIMEOUT_CYC(1023)) dut (
        .G_CLK(G_CLK), .G_RESET(G_RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .CS_l(CS_l), .DS(DS), .RW_l(RW_l), .REG(REG), .DATA_O(DATA_O), .DATA_OE(DATA_OE),
        .DATA_I(DATA_I), .RDY(RDY)
    );

    nm_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .WAIT_IGN_CYC(1), .TIMEOUT_CYC(1023)) dut_s1 (
        .G_CLK(G_CLK), .G_RESET(G_RESET), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready_2),
        .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .rsp_timeout(rsp_timeout_2),
        .CS_l(CS_l_2), .DS(DS_2), .RW_l(RW_l_2), .REG(REG_2), .DATA_O(DATA_O_2),
        .DATA_OE(DATA_OE_2), .DATA_I(DATA_I), .RDY(RDY)
    );

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge G_CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int seen;
        int ds_cnt;

        G_RESET = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_write = 1'b0;
        cmd_reg = 4'h0; cmd_wdata = 16'h0; DATA_I = 16'h0; RDY = 1'b1;
        tick(); tick();
        G_RESET = 1'b0;

        chkb("rst_cs_l", CS_l, 1'b1);
        chkb("rst_ds", DS, 1'b0);
        chkb("rst_rw_l", RW_l, 1'b1);
        chkv("rst_reg", 32'(REG), 32'h0);
        chkb("rst_data_oe", DATA_OE, 1'b0);
        chkv("rst_data_o", 32'(DATA_O), 32'h0);
        chkb("rst_cmd_ready", cmd_ready, 1'b1);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkv("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chkb("rst_rsp_timeout", rsp_timeout, 1'b0);

        // Write 0x0030 to NETWORK_STATUS, RDY always high.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_reg = NETWORK_STATUS; cmd_wdata = 16'h0030;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            chkb("wr_cs_l", CS_l, k == 7);
            chkb("wr_ds", DS, (k == 2) || (k == 3));
            chkb("wr_data_oe", DATA_OE, k <= 6);
            chkb("wr_rsp_valid", rsp_valid, k == 7);
            chkb("wr_cmd_ready", cmd_ready, k == 7);
            if (k == 1) begin
                chkv("wr_reg", 32'(REG), 32'hD);
                chkv("wr_data_o", 32'(DATA_O), 32'h0030);
                chkb("wr_rw_l", RW_l, 1'b0);
            end
        end
        chkb("wr_timeout", rsp_timeout, 1'b0);
        chkv("wr_rdata", 32'(rsp_rdata), 32'h0);

        // Read NETWORK_STATUS with RDY low for 10 cycles after DS falls.
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = NETWORK_STATUS; DATA_I = 16'h000C;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            RDY = !((k >= 4) && (k <= 13));
            chkb("rd_data_oe", DATA_OE, 1'b0);
            chkb("rd_rw_l", RW_l, 1'b1);
            chkb("rd_rsp_valid", rsp_valid, k == 16);
            if (k == 16) begin
                chkv("rd_rdata", 32'(rsp_rdata), 32'h000C);
                chkb("rd_timeout", rsp_timeout, 1'b0);
            end
        end

        // RDY stuck low: abort after 1023 WAIT cycles.
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = 4'h2; DATA_I = 16'hBEEF; RDY = 1'b0;
        got = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            if (rsp_valid) begin
                got = k;
                break;
            end
        end
        chkv("to_cycle", 32'(got), 32'd1028);
        chkb("to_timeout", rsp_timeout, 1'b1);
        chkv("to_rdata", 32'(rsp_rdata), 32'h0);

        // Back-to-back: cmd_valid held; second command taken on the rsp_valid cycle.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_reg = 4'h3; cmd_wdata = 16'h1111;
        RDY = 1'b1; DATA_I = 16'h5A5A;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) begin
                cmd_write = 1'b0; cmd_reg = 4'h5; cmd_wdata = 16'h0;
            end
            if (k == 8) cmd_valid = 1'b0;
            chkb("b2b_cs_l", CS_l, (k == 7) || (k == 14));
            chkb("b2b_rsp_valid", rsp_valid, (k == 7) || (k == 14));
            if (k == 8) begin
                chkv("b2b_reg", 32'(REG), 32'h5);
                chkb("b2b_rw_l", RW_l, 1'b1);
                chkb("b2b_data_oe", DATA_OE, 1'b0);
            end
            if (k == 14) chkv("b2b_rdata", 32'(rsp_rdata), 32'h5A5A);
        end

        // Reset during STROBE drops the access.
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_reg = 4'h1; cmd_wdata = 16'hABCD;
        tick(); cmd_valid = 1'b0;
        tick();
        chkb("rm_ds_before", DS, 1'b1);
        G_RESET = 1'b1;
        tick();
        G_RESET = 1'b0;
        chkb("rm_cs_l", CS_l, 1'b1);
        chkb("rm_ds", DS, 1'b0);
        chkb("rm_data_oe", DATA_OE, 1'b0);
        chkb("rm_rsp_valid", rsp_valid, 1'b0);
        chkb("rm_cmd_ready", cmd_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chkv("rm_no_rsp", 32'(seen), 32'd0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_reg = 4'h4; DATA_I = 16'h1234;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            if (rsp_valid) begin
                got = k;
                break;
            end
        end
        chkv("rm_next_cycle", 32'(got), 32'd7);
        chkv("rm_next_rdata", 32'(rsp_rdata), 32'h1234);

        // Single-cycle strobe instance: FORGET write.
        tick();
        cmd_valid2 = 1'b1; cmd_write = 1'b1; cmd_reg = FORGET; cmd_wdata = 16'h0001;
        got = 0; ds_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) cmd_valid2 = 1'b0;
            if (DS_2) ds_cnt++;
            if (k == 2) chkb("s1_ds", DS_2, 1'b1);
            if (rsp_valid_2) got = k;
        end
        chkv("s1_ds_width", 32'(ds_cnt), 32'd1);
        chkv("s1_rsp_cycle", 32'(got), 32'd6);
        chkb("s1_timeout", rsp_timeout_2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
